// File: rtl/pipe_stage_regs_pkg.sv
// rtl/pipe_stage_regs_pkg.sv - shared constants and control bundle for the MIPS pipeline registers
package mips_pipe_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0;
  localparam logic [4:0]  REG_ZERO  = 5'd0;

  typedef struct packed {
    logic       RegWrite;
    logic       MemtoReg;
    logic       MemWrite;
    logic       ALUSrc;
    logic       RegDst;
    logic       Branch;
    logic [2:0] ALUControl;
  } ctrl_e_t;

  localparam ctrl_e_t BUBBLE_CTRL = '0;

endpackage

// File: rtl/pipe_stage_regs_if.sv
// rtl/pipe_stage_regs_if.sv - fetch/decode/hazard side bundle of the pipeline registers (PIPE_PERF_CNT_EN adds counters)
interface pipe_stage_regs_if #(
  parameter int DW = 32
`ifdef PIPE_PERF_CNT_EN
  , parameter int CNT_W = 32
`endif
);
  logic          StallF, StallD, FlushE, PCSrcD;
  logic [DW-1:0] PCBranchD, PCPlus4F;
  logic [31:0]   InstrF;
  logic [DW-1:0] PCF;
  logic [31:0]   InstrD;
  logic [DW-1:0] PCPlus4D;
  logic          ValidD;
  logic [4:0]    RsD_in, RtD_in, RdD_in;
  logic          RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD, BranchD;
  logic [2:0]    ALUControlD;
  logic [DW-1:0] RD1D, RD2D, SignImmD;
  logic [4:0]    RsE, RtE, RdE;
  logic          RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, BranchE;
  logic [2:0]    ALUControlE;
  logic [DW-1:0] RD1E, RD2E, SignImmE;
  logic          ValidE;
`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] StallCnt, BubbleCnt, BranchCnt;
`endif

  modport master (
    output StallF, StallD, FlushE, PCSrcD, PCBranchD, PCPlus4F, InstrF,
           RsD_in, RtD_in, RdD_in, RegWriteD, MemtoRegD, MemWriteD, ALUSrcD,
           RegDstD, BranchD, ALUControlD, RD1D, RD2D, SignImmD,
    input  PCF, InstrD, PCPlus4D, ValidD, RsE, RtE, RdE, RegWriteE, MemtoRegE,
           MemWriteE, ALUSrcE, RegDstE, BranchE, ALUControlE, RD1E, RD2E,
           SignImmE, ValidE
`ifdef PIPE_PERF_CNT_EN
    , input StallCnt, BubbleCnt, BranchCnt
`endif
  );

  modport slave (
    input  StallF, StallD, FlushE, PCSrcD, PCBranchD, PCPlus4F, InstrF,
           RsD_in, RtD_in, RdD_in, RegWriteD, MemtoRegD, MemWriteD, ALUSrcD,
           RegDstD, BranchD, ALUControlD, RD1D, RD2D, SignImmD,
    output PCF, InstrD, PCPlus4D, ValidD, RsE, RtE, RdE, RegWriteE, MemtoRegE,
           MemWriteE, ALUSrcE, RegDstE, BranchE, ALUControlE, RD1E, RD2E,
           SignImmE, ValidE
`ifdef PIPE_PERF_CNT_EN
    , output StallCnt, BubbleCnt, BranchCnt
`endif
  );
endinterface

// File: rtl/pipe_reg_enclr.sv
// rtl/pipe_reg_enclr.sv - width-parameterised register with async reset, enable and sync clear
module pipe_reg_enclr #(
  parameter int           W       = 32,
  parameter logic [W-1:0] RST_VAL = '0,
  parameter logic [W-1:0] CLR_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] data_q;

  // Clear wins over enable so a squash is never masked by a load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     data_q <= RST_VAL;
    else if (clr_i) data_q <= CLR_VAL;
    else if (en_i)  data_q <= d_i;
  end

  assign q_o = data_q;
endmodule

// File: rtl/pipe_stage_regs.sv
// rtl/pipe_stage_regs.sv - PC, IF/ID and ID/EX registers driven by hazard stall/flush; PIPE_PERF_CNT_EN adds event counters
module pipe_stage_regs
  import mips_pipe_pkg::*;
#(
  parameter int          DW       = 32,
  parameter logic [DW-1:0] RESET_PC = '0
`ifdef PIPE_PERF_CNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input logic              clk,
  input logic              rst_n,
  pipe_stage_regs_if.slave bus
);
  localparam int IFID_W = 1 + DW + 32;
  localparam int IDEX_W = 1 + $bits(ctrl_e_t) + 15 + 3 * DW;
  localparam logic [IFID_W-1:0] IFID_CLR = {1'b0, {DW{1'b0}}, NOP_INSTR};
  localparam logic [IDEX_W-1:0] IDEX_CLR =
    {1'b0, BUBBLE_CTRL, REG_ZERO, REG_ZERO, REG_ZERO, {(3 * DW){1'b0}}};

  logic              take_d;
  logic [DW-1:0]     pc_d, pc_q;
  logic [IFID_W-1:0] ifid_d, ifid_q;
  logic [IDEX_W-1:0] idex_d, idex_q;
  ctrl_e_t           ctrl_d, ctrl_q;

  // A stalled decode may be looking at stale operands, so its branch is ignored.
  assign take_d = bus.PCSrcD & ~bus.StallD;
  assign pc_d   = take_d ? bus.PCBranchD : bus.PCPlus4F;

  pipe_reg_enclr #(.W(DW), .RST_VAL(RESET_PC), .CLR_VAL('0)) u_pc (
    .clk(clk), .rst_n(rst_n), .en_i(~bus.StallF), .clr_i(1'b0),
    .d_i(pc_d), .q_o(pc_q)
  );

  assign ifid_d = {1'b1, bus.PCPlus4F, bus.InstrF};

  pipe_reg_enclr #(.W(IFID_W), .RST_VAL('0), .CLR_VAL(IFID_CLR)) u_ifid (
    .clk(clk), .rst_n(rst_n), .en_i(~bus.StallD), .clr_i(take_d),
    .d_i(ifid_d), .q_o(ifid_q)
  );

  assign ctrl_d = '{RegWrite: bus.RegWriteD, MemtoReg: bus.MemtoRegD,
                    MemWrite: bus.MemWriteD, ALUSrc: bus.ALUSrcD,
                    RegDst: bus.RegDstD, Branch: bus.BranchD,
                    ALUControl: bus.ALUControlD};

  // ValidE masks a stalled decode so the same instruction never issues twice.
  assign idex_d = {bus.ValidD & ~bus.StallD, ctrl_d, bus.RsD_in, bus.RtD_in,
                   bus.RdD_in, bus.RD1D, bus.RD2D, bus.SignImmD};

  pipe_reg_enclr #(.W(IDEX_W), .RST_VAL('0), .CLR_VAL(IDEX_CLR)) u_idex (
    .clk(clk), .rst_n(rst_n), .en_i(1'b1), .clr_i(bus.FlushE),
    .d_i(idex_d), .q_o(idex_q)
  );

  assign bus.PCF = pc_q;
  assign {bus.ValidD, bus.PCPlus4D, bus.InstrD} = ifid_q;
  assign {bus.ValidE, ctrl_q, bus.RsE, bus.RtE, bus.RdE,
          bus.RD1E, bus.RD2E, bus.SignImmE} = idex_q;
  assign bus.RegWriteE   = ctrl_q.RegWrite;
  assign bus.MemtoRegE   = ctrl_q.MemtoReg;
  assign bus.MemWriteE   = ctrl_q.MemWrite;
  assign bus.ALUSrcE     = ctrl_q.ALUSrc;
  assign bus.RegDstE     = ctrl_q.RegDst;
  assign bus.BranchE     = ctrl_q.Branch;
  assign bus.ALUControlE = ctrl_q.ALUControl;

`ifdef PIPE_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;

  // Saturating increments: a counter parked at all-ones stays there.
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    branch_cnt_d = branch_cnt_q;
    if (bus.StallD && !(&stall_cnt_q))  stall_cnt_d  = stall_cnt_q + CNT_ONE;
    if (bus.FlushE && !(&bubble_cnt_q)) bubble_cnt_d = bubble_cnt_q + CNT_ONE;
    if (take_d && !(&branch_cnt_q))     branch_cnt_d = branch_cnt_q + CNT_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
      branch_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
      branch_cnt_q <= branch_cnt_d;
    end
  end

  assign bus.StallCnt  = stall_cnt_q;
  assign bus.BubbleCnt = bubble_cnt_q;
  assign bus.BranchCnt = branch_cnt_q;
`endif
endmodule

// File: tb/tb_pipe_stage_regs.sv
// tb/tb_pipe_stage_regs.sv - directed checks of PC, IF/ID and ID/EX registers (PIPE_PERF_CNT_EN adds counter checks)
module tb_pipe_stage_regs;
  import mips_pipe_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

`ifdef PIPE_PERF_CNT_EN
  pipe_stage_regs_if #(.DW(32), .CNT_W(4)) bus ();
  pipe_stage_regs #(.DW(32), .RESET_PC(32'h0), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
`else
  pipe_stage_regs_if #(.DW(32)) bus ();
  pipe_stage_regs #(.DW(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    bus.StallF = 0; bus.StallD = 0; bus.FlushE = 0; bus.PCSrcD = 0;
    bus.PCBranchD = 0; bus.PCPlus4F = 0; bus.InstrF = 0;
    bus.RsD_in = 0; bus.RtD_in = 0; bus.RdD_in = 0;
    bus.RegWriteD = 0; bus.MemtoRegD = 0; bus.MemWriteD = 0;
    bus.ALUSrcD = 0; bus.RegDstD = 0; bus.BranchD = 0; bus.ALUControlD = 0;
    bus.RD1D = 0; bus.RD2D = 0; bus.SignImmD = 0;
    #2;
    check("rst_pcf", bus.PCF, 32'h0);
    check("rst_instrd", bus.InstrD, 32'h0);
    check("rst_validd", bus.ValidD, 1'b0);
    check("rst_valide", bus.ValidE, 1'b0);
    check("rst_regwritee", bus.RegWriteE, 1'b0);

    bus.RsD_in = 5'd8; bus.RtD_in = 5'd9; bus.RdD_in = 5'd10;
    bus.RegWriteD = 1; bus.MemWriteD = 1; bus.ALUControlD = 3'b010;
    bus.RD1D = 32'hDEAD_BEEF; bus.RD2D = 32'h1234_5678; bus.SignImmD = 32'h4;
    bus.InstrF = 32'h8C08_0004; bus.PCPlus4F = 32'h4;
    #1 rst_n = 1'b1;

    step();
    check("run1_pcf", bus.PCF, 32'h4);
    check("run1_instrd", bus.InstrD, 32'h8C08_0004);
    check("run1_validd", bus.ValidD, 1'b1);
    check("run1_valide", bus.ValidE, 1'b0);

    bus.PCPlus4F = 32'h8;
    step();
    check("run2_pcf", bus.PCF, 32'h8);
    check("run2_valide", bus.ValidE, 1'b1);
    check("run2_rse", bus.RsE, 5'd8);

    // load-use stall
    bus.StallF = 1; bus.StallD = 1; bus.FlushE = 1;
    bus.PCPlus4F = 32'hC; bus.InstrF = 32'h012A_4020;
    step();
    check("stall_pcf", bus.PCF, 32'h8);
    check("stall_instrd", bus.InstrD, 32'h8C08_0004);
    check("stall_validd", bus.ValidD, 1'b1);
    check("stall_valide", bus.ValidE, 1'b0);
    check("stall_regwritee", bus.RegWriteE, 1'b0);
    check("stall_memwritee", bus.MemWriteE, 1'b0);
    check("stall_rse", bus.RsE, 5'd0);
    check("stall_rte", bus.RtE, 5'd0);
    check("stall_rd1e", bus.RD1E, 32'h0);

    bus.StallF = 0; bus.StallD = 0; bus.FlushE = 0;
    step();
    check("resume_pcf", bus.PCF, 32'hC);
    check("resume_instrd", bus.InstrD, 32'h012A_4020);
    check("resume_valide", bus.ValidE, 1'b1);
    check("resume_rse", bus.RsE, 5'd8);
    check("resume_rte", bus.RtE, 5'd9);
    check("resume_rde", bus.RdE, 5'd10);
    check("resume_aluctl", bus.ALUControlE, 3'b010);
    check("resume_rd1e", bus.RD1E, 32'hDEAD_BEEF);
    check("resume_rd2e", bus.RD2E, 32'h1234_5678);
    check("resume_immE", bus.SignImmE, 32'h4);
    check("resume_memwritee", bus.MemWriteE, 1'b1);

    // taken branch with simultaneous flush
    bus.PCSrcD = 1; bus.PCBranchD = 32'h40; bus.FlushE = 1; bus.PCPlus4F = 32'h10;
    step();
    check("br_pcf", bus.PCF, 32'h40);
    check("br_instrd", bus.InstrD, 32'h0);
    check("br_pcplus4d", bus.PCPlus4D, 32'h0);
    check("br_validd", bus.ValidD, 1'b0);
    check("br_valide", bus.ValidE, 1'b0);
    check("br_regwritee", bus.RegWriteE, 1'b0);

    bus.PCSrcD = 0; bus.FlushE = 0; bus.InstrF = 32'h1111_2222; bus.PCPlus4F = 32'h44;
    step();
    check("fill_pcf", bus.PCF, 32'h44);
    check("fill_instrd", bus.InstrD, 32'h1111_2222);
    check("fill_pcplus4d", bus.PCPlus4D, 32'h44);
    check("fill_valide", bus.ValidE, 1'b0);

    // branch during stall must be ignored
    bus.PCSrcD = 1; bus.StallF = 1; bus.StallD = 1; bus.FlushE = 1;
    bus.PCBranchD = 32'h80; bus.PCPlus4F = 32'h48; bus.InstrF = 32'h3333_4444;
    step();
    check("stbr_pcf", bus.PCF, 32'h44);
    check("stbr_instrd", bus.InstrD, 32'h1111_2222);
    check("stbr_validd", bus.ValidD, 1'b1);
    check("stbr_valide", bus.ValidE, 1'b0);

    bus.StallF = 0; bus.StallD = 0; bus.FlushE = 0;
    step();
    check("unst_pcf", bus.PCF, 32'h80);
    check("unst_instrd", bus.InstrD, 32'h0);
    check("unst_validd", bus.ValidD, 1'b0);
    check("unst_valide", bus.ValidE, 1'b1);

    // asynchronous reset between edges while stalled
    bus.PCSrcD = 0; bus.StallF = 1; bus.StallD = 1;
    #3 rst_n = 1'b0;
    #1;
    check("arst_pcf", bus.PCF, 32'h0);
    check("arst_valide", bus.ValidE, 1'b0);
    check("arst_rse", bus.RsE, 5'd0);
    check("arst_regwritee", bus.RegWriteE, 1'b0);

`ifdef PIPE_PERF_CNT_EN
    check("cnt_rst_stall", bus.StallCnt, 4'h0);
    check("cnt_rst_bubble", bus.BubbleCnt, 4'h0);
    check("cnt_rst_branch", bus.BranchCnt, 4'h0);
    bus.StallF = 1; bus.StallD = 1; bus.FlushE = 0; bus.PCSrcD = 1;
    #1 rst_n = 1'b1;
    repeat (20) step();
    check("cnt_stall_sat", bus.StallCnt, 4'hF);
    check("cnt_branch_masked", bus.BranchCnt, 4'h0);
    check("cnt_bubble_idle", bus.BubbleCnt, 4'h0);
    step();
    check("cnt_stall_hold", bus.StallCnt, 4'hF);
    bus.StallF = 0; bus.StallD = 0; bus.FlushE = 1;
    step();
    check("cnt_bubble_one", bus.BubbleCnt, 4'h1);
    check("cnt_branch_one", bus.BranchCnt, 4'h1);
    check("cnt_stall_kept", bus.StallCnt, 4'hF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
